// File: rtl/execute_control_unit.sv
// Execute/write-back control stage: branch resolution against held flags,
// register-file/memory/SP write-back, and stall/flush back to the decode pipeline.
module execute_control_unit #(
    parameter int              W            = 16,
    parameter logic [W-1:0]    SP_INIT      = 16'hFFFF,
    parameter int              FLUSH_CYCLES = 2
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         valid_IN,
    input  logic         input_IN,
    input  logic         wren_IN,
    input  logic         ADR_MUX_IN,
    input  logic         write_IN,
    input  logic         PC_load_IN,
    input  logic         SPR_w_IN,
    input  logic         SPR_i_IN,
    input  logic         SPR_d_IN,
    input  logic         SW_IN,
    input  logic         MAD_MUX_IN,
    input  logic [2:0]   writeAd_IN,
    input  logic [2:0]   cond_IN,
    input  logic [2:0]   op2_IN,
    input  logic [W-1:0] alu_result_IN,
    input  logic [3:0]   alu_flags_IN,
    input  logic [W-1:0] ext_data_IN,
    input  logic         ext_valid_IN,
    output logic         ext_ack_OUT,
    output logic         rf_we_OUT,
    output logic [2:0]   rf_ad_OUT,
    output logic [W-1:0] rf_data_OUT,
    output logic         mem_we_OUT,
    output logic         adr_mux_OUT,
    output logic         sw_OUT,
    output logic         mad_mux_OUT,
    output logic [2:0]   op2_OUT,
    output logic         pc_load_OUT,
    output logic         flush_OUT,
    output logic         stall_OUT,
    output logic [W-1:0] SP_OUT,
    output logic [3:0]   flags_OUT
);

    localparam logic ST_RUN   = 1'b0;
    localparam logic ST_FLUSH = 1'b1;
    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    logic         state_reg, state_next;
    logic [2:0]   cnt_reg, cnt_next;
    logic [3:0]   flags_reg, flags_next;
    logic [W-1:0] sp_reg, sp_next;
    logic [W-1:0] rf_data_reg;
    logic [2:0]   rf_ad_reg;
    logic [2:0]   op2_reg;
    logic         rf_we_reg, mem_we_reg, pc_load_reg, ext_ack_reg;
    logic [2:0]   pass_in, pass_reg;

    logic stall, accept, cond_true, taken;

    assign stall  = valid_IN & input_IN & wren_IN & ~ext_valid_IN & (state_reg == ST_RUN);
    assign accept = valid_IN & ~stall & (state_reg == ST_RUN);

    // Flags layout is {S,Z,C,V}; the condition sees flags before this bundle's update.
    always_comb begin
        cond_true = 1'b0;
        case (cond_IN)
            3'b000:  cond_true =  flags_reg[2];
            3'b001:  cond_true = ~flags_reg[2];
            3'b010:  cond_true =  flags_reg[3];
            3'b011:  cond_true = ~flags_reg[3];
            3'b100:  cond_true =  flags_reg[1];
            3'b101:  cond_true = ~flags_reg[1];
            3'b110:  cond_true =  flags_reg[0];
            default: cond_true =  1'b1;
        endcase
    end

    assign taken = accept & PC_load_IN & cond_true;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_RUN: begin
                if (taken) begin
                    state_next = ST_FLUSH;
                    cnt_next   = FLUSH_LOAD;
                end
            end
            default: begin
                if (cnt_reg == 3'd0) begin
                    state_next = ST_RUN;
                end else begin
                    cnt_next = cnt_reg - 3'd1;
                end
            end
        endcase
    end

    always_comb begin
        flags_next = flags_reg;
        if (accept && wren_IN && !input_IN) begin
            flags_next = alu_flags_IN;
        end
    end

    always_comb begin
        sp_next = sp_reg;
        if (accept) begin
            if (SPR_w_IN) begin
                sp_next = alu_result_IN;
            end else if (SPR_i_IN) begin
                sp_next = sp_reg + {{(W-1){1'b0}}, 1'b1};
            end else if (SPR_d_IN) begin
                sp_next = sp_reg - {{(W-1){1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg   <= ST_RUN;
            cnt_reg     <= 3'd0;
            flags_reg   <= 4'd0;
            sp_reg      <= SP_INIT;
            rf_we_reg   <= 1'b0;
            rf_ad_reg   <= 3'd0;
            rf_data_reg <= '0;
            mem_we_reg  <= 1'b0;
            pc_load_reg <= 1'b0;
            ext_ack_reg <= 1'b0;
            op2_reg     <= 3'd0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            flags_reg   <= flags_next;
            sp_reg      <= sp_next;
            rf_we_reg   <= accept & wren_IN;
            mem_we_reg  <= accept & write_IN;
            pc_load_reg <= taken;
            ext_ack_reg <= accept & wren_IN & input_IN;
            if (accept && wren_IN) begin
                rf_ad_reg   <= writeAd_IN;
                rf_data_reg <= input_IN ? ext_data_IN : alu_result_IN;
            end
            if (accept) begin
                op2_reg <= op2_IN;
            end
        end
    end

    // Single-bit pass-through controls, captured with each accepted bundle.
    assign pass_in = {ADR_MUX_IN, SW_IN, MAD_MUX_IN};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_pass
            always_ff @(posedge CLK) begin
                if (RST) begin
                    pass_reg[gi] <= 1'b0;
                end else if (accept) begin
                    pass_reg[gi] <= pass_in[gi];
                end
            end
        end
    endgenerate

    assign stall_OUT   = stall;
    assign flush_OUT   = (state_reg == ST_FLUSH);
    assign pc_load_OUT = pc_load_reg;
    assign rf_we_OUT   = rf_we_reg;
    assign rf_ad_OUT   = rf_ad_reg;
    assign rf_data_OUT = rf_data_reg;
    assign mem_we_OUT  = mem_we_reg;
    assign ext_ack_OUT = ext_ack_reg;
    assign op2_OUT     = op2_reg;
    assign adr_mux_OUT = pass_reg[2];
    assign sw_OUT      = pass_reg[1];
    assign mad_mux_OUT = pass_reg[0];
    assign SP_OUT      = sp_reg;
    assign flags_OUT   = flags_reg;

endmodule

// File: tb/tb_execute_control_unit.sv
// Scoreboard bench for execute_control_unit: directed scenarios then random
// bundles, checked against a cycle-level behavioural model.
module tb_execute_control_unit;

    localparam int FLUSH_CYCLES = 2;

    logic        CLK = 1'b0;
    logic        RST;
    logic        valid_IN, input_IN, wren_IN, ADR_MUX_IN, write_IN, PC_load_IN;
    logic        SPR_w_IN, SPR_i_IN, SPR_d_IN, SW_IN, MAD_MUX_IN;
    logic [2:0]  writeAd_IN, cond_IN, op2_IN;
    logic [15:0] alu_result_IN, ext_data_IN;
    logic [3:0]  alu_flags_IN;
    logic        ext_valid_IN;
    logic        ext_ack_OUT, rf_we_OUT, mem_we_OUT, adr_mux_OUT, sw_OUT, mad_mux_OUT;
    logic        pc_load_OUT, flush_OUT, stall_OUT;
    logic [2:0]  rf_ad_OUT, op2_OUT;
    logic [15:0] rf_data_OUT, SP_OUT;
    logic [3:0]  flags_OUT;

    execute_control_unit #(.W(16), .SP_INIT(16'hFFFF), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
        .CLK(CLK), .RST(RST), .valid_IN(valid_IN), .input_IN(input_IN), .wren_IN(wren_IN),
        .ADR_MUX_IN(ADR_MUX_IN), .write_IN(write_IN), .PC_load_IN(PC_load_IN),
        .SPR_w_IN(SPR_w_IN), .SPR_i_IN(SPR_i_IN), .SPR_d_IN(SPR_d_IN), .SW_IN(SW_IN),
        .MAD_MUX_IN(MAD_MUX_IN), .writeAd_IN(writeAd_IN), .cond_IN(cond_IN), .op2_IN(op2_IN),
        .alu_result_IN(alu_result_IN), .alu_flags_IN(alu_flags_IN), .ext_data_IN(ext_data_IN),
        .ext_valid_IN(ext_valid_IN), .ext_ack_OUT(ext_ack_OUT), .rf_we_OUT(rf_we_OUT),
        .rf_ad_OUT(rf_ad_OUT), .rf_data_OUT(rf_data_OUT), .mem_we_OUT(mem_we_OUT),
        .adr_mux_OUT(adr_mux_OUT), .sw_OUT(sw_OUT), .mad_mux_OUT(mad_mux_OUT), .op2_OUT(op2_OUT),
        .pc_load_OUT(pc_load_OUT), .flush_OUT(flush_OUT), .stall_OUT(stall_OUT),
        .SP_OUT(SP_OUT), .flags_OUT(flags_OUT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        valid, inp, wren, adr_mux, write, pc_load, spr_w, spr_i, spr_d, sw, mad_mux;
        logic [2:0]  wad, cond, op2;
        logic [15:0] alu;
        logic [3:0]  aflags;
    } bundle_t;

    typedef struct {
        logic        stall, rf_we, mem_we, adr_mux, sw, mad_mux, pc_load, flush, ext_ack;
        logic [2:0]  rf_ad, op2;
        logic [15:0] rf_data, sp;
        logic [3:0]  flags;
    } exp_t;

    exp_t q[$];
    exp_t m;          // model of registered outputs
    exp_t mon_e;
    int   m_flush_left;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic cond_holds(input logic [2:0] c, input logic [3:0] f);
        logic s, z, cy, v;
        {s, z, cy, v} = f;
        case (c)
            3'd0: return z;
            3'd1: return !z;
            3'd2: return s;
            3'd3: return !s;
            3'd4: return cy;
            3'd5: return !cy;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction

    // Applies inputs for one cycle, predicts the response, and advances past the edge.
    task automatic step(input bundle_t b, input logic rst, input logic ev, input logic [15:0] ed,
                        output logic stalled);
        exp_t  e;
        logic  in_flush, acc, tk;
        RST = rst; valid_IN = b.valid; input_IN = b.inp; wren_IN = b.wren;
        ADR_MUX_IN = b.adr_mux; write_IN = b.write; PC_load_IN = b.pc_load;
        SPR_w_IN = b.spr_w; SPR_i_IN = b.spr_i; SPR_d_IN = b.spr_d; SW_IN = b.sw;
        MAD_MUX_IN = b.mad_mux; writeAd_IN = b.wad; cond_IN = b.cond; op2_IN = b.op2;
        alu_result_IN = b.alu; alu_flags_IN = b.aflags; ext_valid_IN = ev; ext_data_IN = ed;

        in_flush = (m_flush_left > 0);
        stalled  = b.valid && b.inp && b.wren && !ev && !in_flush;
        if (rst) begin
            m = '{default: '0};
            m.sp = 16'hFFFF;
            m_flush_left = 0;
        end else begin
            acc = b.valid && !stalled && !in_flush;
            m.rf_we = 0; m.mem_we = 0; m.pc_load = 0; m.ext_ack = 0;
            if (in_flush) m_flush_left--;
            if (acc) begin
                tk = b.pc_load && cond_holds(b.cond, m.flags);
                m.adr_mux = b.adr_mux; m.sw = b.sw; m.mad_mux = b.mad_mux; m.op2 = b.op2;
                if (b.wren) begin
                    m.rf_we = 1; m.rf_ad = b.wad;
                    m.rf_data = b.inp ? ed : b.alu;
                    if (b.inp) m.ext_ack = 1;
                    else       m.flags = b.aflags;
                end
                if (b.write) m.mem_we = 1;
                if (b.spr_w)      m.sp = b.alu;
                else if (b.spr_i) m.sp = m.sp + 16'd1;
                else if (b.spr_d) m.sp = m.sp - 16'd1;
                if (tk) begin
                    m.pc_load = 1;
                    m_flush_left = FLUSH_CYCLES;
                end
            end
        end
        m.flush = (m_flush_left > 0);
        e = m;
        e.stall = stalled;
        q.push_back(e);
        @(posedge CLK);
        #1;
    endtask

    // Monitor: stall is checked mid-cycle, registered outputs just after the edge.
    initial begin
        forever begin
            @(negedge CLK);
            if (q.size() > 0) begin
                mon_e = q.pop_front();
                chk("stall", 32'(stall_OUT), 32'(mon_e.stall));
                @(posedge CLK);
                #2;
                chk("rf_we",   32'(rf_we_OUT),   32'(mon_e.rf_we));
                chk("rf_ad",   32'(rf_ad_OUT),   32'(mon_e.rf_ad));
                chk("rf_data", 32'(rf_data_OUT), 32'(mon_e.rf_data));
                chk("mem_we",  32'(mem_we_OUT),  32'(mon_e.mem_we));
                chk("adr_mux", 32'(adr_mux_OUT), 32'(mon_e.adr_mux));
                chk("sw",      32'(sw_OUT),      32'(mon_e.sw));
                chk("mad_mux", 32'(mad_mux_OUT), 32'(mon_e.mad_mux));
                chk("op2",     32'(op2_OUT),     32'(mon_e.op2));
                chk("pc_load", 32'(pc_load_OUT), 32'(mon_e.pc_load));
                chk("flush",   32'(flush_OUT),   32'(mon_e.flush));
                chk("ext_ack", 32'(ext_ack_OUT), 32'(mon_e.ext_ack));
                chk("sp",      32'(SP_OUT),      32'(mon_e.sp));
                chk("flags",   32'(flags_OUT),   32'(mon_e.flags));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

    function automatic bundle_t rand_bundle();
        bundle_t b;
        b.valid   = ($urandom_range(0, 9) < 8);
        b.inp     = ($urandom_range(0, 9) < 2);
        b.wren    = $urandom_range(0, 1) == 1;
        b.adr_mux = $urandom_range(0, 1) == 1;
        b.write   = ($urandom_range(0, 9) < 2);
        b.pc_load = ($urandom_range(0, 9) < 2);
        b.spr_w   = ($urandom_range(0, 9) < 1);
        b.spr_i   = ($urandom_range(0, 9) < 2);
        b.spr_d   = ($urandom_range(0, 9) < 2);
        b.sw      = $urandom_range(0, 1) == 1;
        b.mad_mux = $urandom_range(0, 1) == 1;
        b.wad     = 3'($urandom_range(0, 7));
        b.cond    = 3'($urandom_range(0, 7));
        b.op2     = 3'($urandom_range(0, 7));
        b.alu     = 16'($urandom());
        b.aflags  = 4'($urandom_range(0, 15));
        return b;
    endfunction

    initial begin
        bundle_t idle, b;
        logic    st;
        logic    rst_r, ev_r;
        idle = '{default: '0};
        m = '{default: '0};
        m.sp = 16'hFFFF;
        m_flush_left = 0;
        RST = 1; valid_IN = 0; input_IN = 0; wren_IN = 0; ADR_MUX_IN = 0; write_IN = 0;
        PC_load_IN = 0; SPR_w_IN = 0; SPR_i_IN = 0; SPR_d_IN = 0; SW_IN = 0; MAD_MUX_IN = 0;
        writeAd_IN = 0; cond_IN = 0; op2_IN = 0; alu_result_IN = 0; alu_flags_IN = 0;
        ext_valid_IN = 0; ext_data_IN = 0;
        @(posedge CLK);
        #1;

        // Reset then idle
        step(idle, 1, 0, 16'h0, st);
        step(idle, 1, 0, 16'h0, st);
        step(idle, 0, 0, 16'h0, st);
        chk("tp_reset_sp", 32'(SP_OUT), 32'h0000FFFF);

        // ALU write sets Z
        b = idle; b.valid = 1; b.wren = 1; b.wad = 3'd5; b.alu = 16'h1234; b.aflags = 4'b0100;
        step(b, 0, 0, 16'h0, st);
        chk("tp_alu_rf_data", 32'(rf_data_OUT), 32'h1234);
        chk("tp_alu_flags", 32'(flags_OUT), 32'h4);

        // Taken branch on Z, two discarded bundles, then a not-taken !Z branch
        b = idle; b.valid = 1; b.pc_load = 1; b.cond = 3'b000;
        step(b, 0, 0, 16'h0, st);
        chk("tp_branch_pc_load", 32'(pc_load_OUT), 32'h1);
        b = idle; b.valid = 1; b.wren = 1; b.wad = 3'd7; b.alu = 16'hBEEF;
        step(b, 0, 0, 16'h0, st);
        step(b, 0, 0, 16'h0, st);
        b = idle; b.valid = 1; b.pc_load = 1; b.cond = 3'b001;
        step(b, 0, 0, 16'h0, st);
        chk("tp_nottaken_pc_load", 32'(pc_load_OUT), 32'h0);
        step(idle, 0, 0, 16'h0, st);

        // Input stall for three cycles, then the word arrives
        b = idle; b.valid = 1; b.inp = 1; b.wren = 1; b.wad = 3'd2;
        repeat (3) step(b, 0, 0, 16'h0, st);
        step(b, 0, 1, 16'h00AB, st);
        chk("tp_input_rf_data", 32'(rf_data_OUT), 32'h00AB);
        step(idle, 0, 0, 16'h0, st);

        // SP wrap both ways and SPR_w priority
        b = idle; b.valid = 1; b.spr_i = 1;
        step(b, 0, 0, 16'h0, st);
        chk("tp_sp_wrap_up", 32'(SP_OUT), 32'h0);
        b = idle; b.valid = 1; b.spr_d = 1;
        step(b, 0, 0, 16'h0, st);
        chk("tp_sp_wrap_down", 32'(SP_OUT), 32'hFFFF);
        b = idle; b.valid = 1; b.spr_w = 1; b.spr_i = 1; b.alu = 16'h0100;
        step(b, 0, 0, 16'h0, st);
        chk("tp_sp_priority", 32'(SP_OUT), 32'h0100);

        // Reset during the second flush cycle, then a bundle is accepted
        b = idle; b.valid = 1; b.pc_load = 1; b.cond = 3'b111;
        step(b, 0, 0, 16'h0, st);
        step(idle, 0, 0, 16'h0, st);
        step(idle, 1, 0, 16'h0, st);
        chk("tp_rst_flush", 32'(flush_OUT), 32'h0);
        b = idle; b.valid = 1; b.wren = 1; b.wad = 3'd3; b.alu = 16'h5A5A;
        step(b, 0, 0, 16'h0, st);
        chk("tp_after_rst_rf_we", 32'(rf_we_OUT), 32'h1);

        // Randomised traffic; a stalled bundle is held until consumed or reset
        st = 0;
        b = rand_bundle();
        for (int i = 0; i < 3000; i++) begin
            if (!st) b = rand_bundle();
            rst_r = ($urandom_range(0, 99) < 2);
            ev_r  = $urandom_range(0, 2) != 0;
            step(b, rst_r, ev_r, 16'($urandom()), st);
            if (rst_r) st = 0;
        end
        step(idle, 0, 0, 16'h0, st);

        @(posedge CLK);
        @(posedge CLK);
        #3;
        chk("queue_drained", 32'(q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
